// File: rtl/intm_rs_age_pkg.sv
// rtl/intm_rs_age_pkg.sv - shared types, sizes and helpers for the mul/div reservation station
package intm_rs_age_pkg;

  localparam int DEPTH     = 8;
  localparam int ID_WIDTH  = 2;
  localparam int CDB_WIDTH = 3;
  localparam int NUM_FU    = 2;
  localparam int PRF_IDX   = 6;
  localparam int ROB_IDX   = 6;
  localparam int ARCH_IDX  = 5;
  localparam int OPC_W     = 4;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int FU_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int LANE_W    = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;
  localparam int OCC_W     = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ROB_IDX-1:0]  rob_id;
    logic [PRF_IDX-1:0]  rs1_phy;
    logic                rs1_valid;
    logic [PRF_IDX-1:0]  rs2_phy;
    logic                rs2_valid;
    logic [PRF_IDX-1:0]  rd_phy;
    logic [ARCH_IDX-1:0] rd_arch;
    logic [OPC_W-1:0]    fu_opcode;
    logic [FU_W-1:0]     fu_sel;
  } rs_entry_t;

  function automatic logic [OCC_W-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + OCC_W'(v[i]);
    return cnt;
  endfunction

  // True when any live CDB bus is broadcasting the given physical tag.
  function automatic logic cdb_hit(input logic [CDB_WIDTH-1:0]              v,
                                   input logic [CDB_WIDTH-1:0][PRF_IDX-1:0] t,
                                   input logic [PRF_IDX-1:0]                tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_WIDTH; k++) hit = hit | (v[k] & (t[k] == tag));
    return hit;
  endfunction

endpackage

// File: rtl/intm_rs_age_arb.sv
// rtl/intm_rs_age_arb.sv - age matrix with per-class oldest-requester grant
module intm_rs_age_arb
  import intm_rs_age_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [DEPTH-1:0]              valid,
  input  logic [DEPTH-1:0]              alloc,
  input  logic [DEPTH-1:0]              dealloc,
  input  logic [NUM_FU-1:0][DEPTH-1:0]  class_req,
  output logic [NUM_FU-1:0][DEPTH-1:0]  grant
);

  // old_q[j][i] = 1 means entry j is older than entry i
  logic [DEPTH-1:0][DEPTH-1:0] old_q, old_d;

  // Next matrix: a new entry is younger than everything live; same-cycle
  // allocations land in slots that increase with lane number, so the lower
  // slot index is the lower (older) lane.
  always_comb begin
    old_d = old_q;
    for (int j = 0; j < DEPTH; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == j)                        old_d[j][i] = 1'b0;
        else if (alloc[j])                 old_d[j][i] = alloc[i] && (i > j);
        else if (alloc[i])                 old_d[j][i] = valid[j] & ~dealloc[j];
        else if (dealloc[j] | dealloc[i])  old_d[j][i] = 1'b0;
      end
    end
  end

  // Matrix register; flush forgets all ordering along with the entries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       old_q <= '0;
    else if (flush) old_q <= '0;
    else            old_q <= old_d;
  end

  // Grant a requester only when no older entry of the same class is requesting
  always_comb begin
    grant = '0;
    for (int c = 0; c < NUM_FU; c++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic blocked;
        blocked = 1'b0;
        for (int j = 0; j < DEPTH; j++)
          if (j != i) blocked = blocked | (class_req[c][j] & old_q[j][i]);
        grant[c][i] = class_req[c][i] & ~blocked;
      end
    end
  end

endmodule

// File: rtl/intm_rs_age.sv
// rtl/intm_rs_age.sv - integer mul/div reservation station, oldest-ready-first issue
module intm_rs_age
  import intm_rs_age_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [ID_WIDTH-1:0]               ds_valid,
  input  rs_entry_t [ID_WIDTH-1:0]          ds_entry,
  output logic                              ds_ready,
  input  logic [CDB_WIDTH-1:0]              cdb_valid,
  input  logic [CDB_WIDTH-1:0][PRF_IDX-1:0] cdb_tag,
  input  logic [NUM_FU-1:0]                 fu_ready,
  output logic [NUM_FU-1:0]                 iss_valid,
  output rs_entry_t [NUM_FU-1:0]            iss_entry,
  output logic [OCC_W-1:0]                  occupancy
);

  logic [DEPTH-1:0]             valid_q;
  rs_entry_t                    ent_q [DEPTH];
  logic [DEPTH-1:0]             alloc, dealloc, req;
  logic [DEPTH-1:0][LANE_W-1:0] alloc_lane;
  logic [ID_WIDTH-1:0]          lane_fire;
  rs_entry_t [ID_WIDTH-1:0]     ds_woke;
  logic [NUM_FU-1:0][DEPTH-1:0] class_req, grant;

  assign ds_ready  = popcnt(~valid_q) >= OCC_W'(ID_WIDTH);
  assign lane_fire = ds_valid & {ID_WIDTH{ds_ready & ~flush}};

  // Free-slot picker: lane w gets the w-th lowest free slot of cycle-start state
  always_comb begin
    int rank;
    alloc      = '0;
    alloc_lane = '0;
    rank       = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i]) begin
        if (rank < ID_WIDTH) begin
          alloc[i]      = lane_fire[LANE_W'(rank)];
          alloc_lane[i] = LANE_W'(rank);
        end
        rank = rank + 1;
      end
    end
  end

  // Incoming uops see this cycle's CDB so a just-produced source arrives ready
  always_comb begin
    ds_woke = ds_entry;
    for (int w = 0; w < ID_WIDTH; w++) begin
      ds_woke[w].rs1_valid = ds_entry[w].rs1_valid | cdb_hit(cdb_valid, cdb_tag, ds_entry[w].rs1_phy);
      ds_woke[w].rs2_valid = ds_entry[w].rs2_valid | cdb_hit(cdb_valid, cdb_tag, ds_entry[w].rs2_phy);
    end
  end

  // Payload storage and wakeup; payloads need no reset since valid_q guards them
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc[i]) begin
        ent_q[i] <= ds_woke[alloc_lane[i]];
      end else begin
        if (cdb_hit(cdb_valid, cdb_tag, ent_q[i].rs1_phy)) ent_q[i].rs1_valid <= 1'b1;
        if (cdb_hit(cdb_valid, cdb_tag, ent_q[i].rs2_phy)) ent_q[i].rs2_valid <= 1'b1;
      end
    end
  end

  // Ready requests per channel, from registered state only
  always_comb begin
    req       = '0;
    class_req = '0;
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = valid_q[i] & ent_q[i].rs1_valid & ent_q[i].rs2_valid;
      for (int c = 0; c < NUM_FU; c++)
        class_req[c][i] = req[i] && (ent_q[i].fu_sel == FU_W'(c));
    end
  end

  intm_rs_age_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .valid     (valid_q),
    .alloc     (alloc),
    .dealloc   (dealloc),
    .class_req (class_req),
    .grant     (grant)
  );

  // One-hot output select per channel; a transfer frees the granted slot
  always_comb begin
    dealloc = '0;
    for (int c = 0; c < NUM_FU; c++) begin
      rs_entry_t sel;
      sel = '0;
      for (int i = 0; i < DEPTH; i++)
        if (grant[c][i]) sel = sel | ent_q[i];
      iss_entry[c]           = sel;
      iss_entry[c].rs1_valid = 1'b1;
      iss_entry[c].rs2_valid = 1'b1;
      iss_valid[c]           = (|class_req[c]) & ~flush;
      if (iss_valid[c] & fu_ready[c]) dealloc = dealloc | grant[c];
    end
  end

  // Entry valid bits and occupancy; flush drops this cycle's dispatch and issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= '0;
      occupancy <= '0;
    end else if (flush) begin
      valid_q   <= '0;
      occupancy <= '0;
    end else begin
      valid_q   <= (valid_q & ~dealloc) | alloc;
      occupancy <= occupancy + popcnt(alloc) - popcnt(dealloc);
    end
  end

endmodule

// File: tb/tb_intm_rs_age.sv
// tb/tb_intm_rs_age.sv - randomized scoreboard bench for intm_rs_age
module tb_intm_rs_age;
  import intm_rs_age_pkg::*;

  logic                              clk = 1'b0;
  logic                              rst;
  logic                              flush;
  logic [ID_WIDTH-1:0]               ds_valid;
  rs_entry_t [ID_WIDTH-1:0]          ds_entry;
  logic                              ds_ready;
  logic [CDB_WIDTH-1:0]              cdb_valid;
  logic [CDB_WIDTH-1:0][PRF_IDX-1:0] cdb_tag;
  logic [NUM_FU-1:0]                 fu_ready;
  logic [NUM_FU-1:0]                 iss_valid;
  rs_entry_t [NUM_FU-1:0]            iss_entry;
  logic [OCC_W-1:0]                  occupancy;

  always #5 clk = ~clk;

  intm_rs_age dut (
    .clk(clk), .rst(rst), .flush(flush), .ds_valid(ds_valid), .ds_entry(ds_entry),
    .ds_ready(ds_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_entry(iss_entry), .occupancy(occupancy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: live uops in dispatch order, each tagged with an age number
  typedef struct {
    rs_entry_t e;
    int        seq;
  } m_ent_t;

  m_ent_t    mq[$];
  int        seq_ctr = 0;
  rs_entry_t exp_q0[$];
  rs_entry_t exp_q1[$];
  logic [ROB_IDX-1:0] rob_ctr = '0;

  function automatic bit hit(input logic [PRF_IDX-1:0] t);
    for (int k = 0; k < CDB_WIDTH; k++)
      if (cdb_valid[k] && cdb_tag[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic rs_entry_t mk(input logic [ROB_IDX-1:0] rob, input logic [FU_W-1:0] fu,
                                   input logic [PRF_IDX-1:0] p1, input logic v1,
                                   input logic [PRF_IDX-1:0] p2, input logic v2);
    rs_entry_t e;
    e.rob_id    = rob;
    e.rs1_phy   = p1;
    e.rs1_valid = v1;
    e.rs2_phy   = p2;
    e.rs2_valid = v2;
    e.rd_phy    = PRF_IDX'($urandom_range(0, 63));
    e.rd_arch   = ARCH_IDX'($urandom_range(0, 31));
    e.fu_opcode = OPC_W'($urandom_range(0, 15));
    e.fu_sel    = fu;
    return e;
  endfunction

  // Compare cycle outputs with the model, then advance the model across the edge
  task automatic model_step();
    int  n;
    bit  exp_rdy;
    int  pick [NUM_FU];
    bit  exp_v [NUM_FU];
    int  rm_hi, rm_lo;
    m_ent_t t;
    if (!rst) begin
      check("rst_ds_ready", 64'(ds_ready), 64'd1);
      check("rst_iss_valid", 64'(iss_valid), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      mq.delete();
      return;
    end
    n       = mq.size();
    exp_rdy = (DEPTH - n) >= ID_WIDTH;
    check("ds_ready", 64'(ds_ready), 64'(exp_rdy));
    check("occupancy", 64'(occupancy), 64'(n));
    for (int c = 0; c < NUM_FU; c++) begin
      pick[c] = -1;
      for (int k = 0; k < n; k++)
        if (mq[k].e.rs1_valid && mq[k].e.rs2_valid && int'(mq[k].e.fu_sel) == c &&
            (pick[c] < 0 || mq[k].seq < mq[pick[c]].seq))
          pick[c] = k;
      exp_v[c] = (pick[c] >= 0) && !flush;
      check($sformatf("iss_valid[%0d]", c), 64'(iss_valid[c]), 64'(exp_v[c]));
    end
    if (flush) begin
      mq.delete();
      return;
    end
    rm_hi = -1;
    rm_lo = -1;
    for (int c = 0; c < NUM_FU; c++) begin
      if (exp_v[c] && fu_ready[c]) begin
        rs_entry_t x;
        x = mq[pick[c]].e;
        x.rs1_valid = 1'b1;
        x.rs2_valid = 1'b1;
        if (c == 0) exp_q0.push_back(x);
        else        exp_q1.push_back(x);
        if (rm_hi < 0) rm_hi = pick[c];
        else if (pick[c] > rm_hi) begin rm_lo = rm_hi; rm_hi = pick[c]; end
        else rm_lo = pick[c];
      end
    end
    for (int k = 0; k < n; k++) begin
      t = mq[k];
      if (hit(t.e.rs1_phy)) t.e.rs1_valid = 1'b1;
      if (hit(t.e.rs2_phy)) t.e.rs2_valid = 1'b1;
      mq[k] = t;
    end
    if (rm_hi >= 0) mq.delete(rm_hi);
    if (rm_lo >= 0) mq.delete(rm_lo);
    if (exp_rdy) begin
      for (int w = 0; w < ID_WIDTH; w++) begin
        if (ds_valid[w]) begin
          t.e   = ds_entry[w];
          t.seq = seq_ctr++;
          if (hit(t.e.rs1_phy)) t.e.rs1_valid = 1'b1;
          if (hit(t.e.rs2_phy)) t.e.rs2_valid = 1'b1;
          mq.push_back(t);
        end
      end
    end
  endtask

  // Monitor: every accepted issue must match the next expected uop on its channel
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        for (int c = 0; c < NUM_FU; c++) begin
          if (iss_valid[c] && fu_ready[c]) begin
            rs_entry_t x;
            if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
              checks++;
              failures++;
              $display("FAIL unexpected_issue ch=%0d rob=%0d", c, iss_entry[c].rob_id);
            end else begin
              x = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check($sformatf("iss_entry[%0d]", c), 64'(iss_entry[c]), 64'(x));
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ds_valid  = '0;
    cdb_valid = '0;
    flush     = 1'b0;
  endtask

  task automatic bcast(input int t0, input int t1, input int t2);
    cdb_valid  = '1;
    cdb_tag[0] = PRF_IDX'(t0);
    cdb_tag[1] = PRF_IDX'(t1);
    cdb_tag[2] = PRF_IDX'(t2);
  endtask

  initial begin
    rst = 1'b0; quiet(); fu_ready = '0; ds_entry = '0; cdb_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_step();
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // Oldest-first: rob 5 then rob 3 on the mul channel
    ds_valid = 2'b01; ds_entry[0] = mk(6'd5, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1); step();
    ds_entry[0] = mk(6'd3, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1); step();
    quiet(); step();
    fu_ready = 2'b01; #3;
    check("oldest_first_a", 64'(iss_entry[0].rob_id), 64'd5); step();
    #3; check("oldest_first_b", 64'(iss_entry[0].rob_id), 64'd3); step();

    // Dual channel in one cycle
    fu_ready = 2'b00; ds_valid = 2'b11;
    ds_entry[0] = mk(6'd1, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1);
    ds_entry[1] = mk(6'd2, 1'b1, 6'd1, 1'b1, 6'd2, 1'b1);
    step(); quiet(); step();
    fu_ready = 2'b11; #3;
    check("dual_iss_valid", 64'(iss_valid), 64'd3);
    check("dual_occ_before", 64'(occupancy), 64'd2); step();
    #3; check("dual_occ_after", 64'(occupancy), 64'd0);

    // Wakeup: later broadcast, then broadcast in the dispatch cycle
    fu_ready = 2'b01; ds_valid = 2'b01;
    ds_entry[0] = mk(6'd7, 1'b0, 6'd12, 1'b0, 6'd2, 1'b1); step();
    quiet(); bcast(12, 12, 12); #3; check("wake_not_yet", 64'(iss_valid[0]), 64'd0); step();
    quiet(); #3; check("wake_issue", 64'(iss_valid[0]), 64'd1);
    check("wake_rob", 64'(iss_entry[0].rob_id), 64'd7); step();
    ds_valid = 2'b01; ds_entry[0] = mk(6'd8, 1'b0, 6'd13, 1'b0, 6'd2, 1'b1);
    bcast(13, 13, 13); step();
    quiet(); #3; check("same_cycle_wake", 64'(iss_valid[0]), 64'd1);
    check("same_cycle_rob", 64'(iss_entry[0].rob_id), 64'd8); step();

    // Full: seven waiting entries leave one slot, so no full group fits
    fu_ready = 2'b00;
    for (int k = 0; k < DEPTH - 1; k += 2) begin
      ds_valid = (k + 1 < DEPTH - 1) ? 2'b11 : 2'b01;
      ds_entry[0] = mk(6'(10 + k), 1'b0, 6'(40 + k), 1'b0, 6'd2, 1'b1);
      ds_entry[1] = mk(6'(11 + k), 1'b0, 6'(41 + k), 1'b0, 6'd2, 1'b1);
      step();
    end
    quiet(); #3; check("full_ds_ready", 64'(ds_ready), 64'd0); step();
    bcast(40, 40, 40); step();
    quiet(); fu_ready = 2'b01; step();
    #3; check("full_reopen", 64'(ds_ready), 64'd1);
    bcast(41, 42, 43); step(); bcast(44, 45, 46); step();
    quiet(); fu_ready = 2'b11;
    repeat (8) step();

    // Flush with a dispatch group in flight
    fu_ready = 2'b00;
    for (int k = 0; k < 5; k++) begin
      ds_valid = 2'b01; ds_entry[0] = mk(6'(20 + k), 1'b1, 6'(50 + k), 1'b0, 6'd2, 1'b1); step();
    end
    ds_valid = 2'b11; flush = 1'b1; fu_ready = 2'b11;
    ds_entry[0] = mk(6'd60, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1);
    ds_entry[1] = mk(6'd61, 1'b1, 6'd1, 1'b1, 6'd2, 1'b1);
    step();
    quiet(); #3;
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_iss", 64'(iss_valid), 64'd0);
    bcast(50, 51, 52); step(); bcast(53, 54, 1); step(); quiet(); repeat (3) step();

    // Random traffic with rare flushes and one asynchronous reset
    for (int cyc = 0; cyc < 1500; cyc++) begin
      ds_valid = ID_WIDTH'($urandom_range(0, 3));
      for (int w = 0; w < ID_WIDTH; w++) begin
        ds_entry[w] = mk(rob_ctr, FU_W'($urandom_range(0, 1)),
                         PRF_IDX'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                         PRF_IDX'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        rob_ctr = rob_ctr + 1'b1;
      end
      cdb_valid = CDB_WIDTH'($urandom_range(0, 7));
      for (int k = 0; k < CDB_WIDTH; k++) cdb_tag[k] = PRF_IDX'($urandom_range(0, 15));
      fu_ready = NUM_FU'($urandom_range(0, 3));
      flush    = ($urandom_range(0, 63) == 0);
      rst      = !(cyc == 700 || cyc == 701);
      step();
    end
    rst = 1'b1;

    // Drain: wake every tag and keep both channels open
    quiet(); fu_ready = 2'b11;
    for (int k = 0; k < 30; k++) begin
      bcast((3 * k) % 16, (3 * k + 1) % 16, (3 * k + 2) % 16);
      step();
    end
    quiet(); repeat (4) step();
    check("drain_model_empty", 64'(mq.size()), 64'd0);
    check("drain_occupancy", 64'(occupancy), 64'd0);
    check("drain_pending_q", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
